// File: rtl/xor_share_encoder.sv
// Two-share Boolean masking encoder: splits operands a/b into registered shares using
// fresh randomness and supplies the refresh words r0..r2 for the masked XOR gadget.
module xor_share_encoder #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_a_i,
  input  logic [W-1:0] in_b_i,
  input  logic         rnd_valid_i,
  output logic         rnd_ready_o,
  input  logic [W-1:0] rnd_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] a0_o,
  output logic [W-1:0] a1_o,
  output logic [W-1:0] b0_o,
  output logic [W-1:0] b1_o,
  output logic [W-1:0] r0_o,
  output logic [W-1:0] r1_o,
  output logic [W-1:0] r2_o,
  output logic [15:0]  word_count_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StEmit  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [W-1:0] a0_q, a0_d;
  logic [W-1:0] a1_q, a1_d;
  logic [W-1:0] b0_q, b0_d;
  logic [W-1:0] b1_q, b1_d;
  logic [W-1:0] r0_q, r0_d;
  logic [W-1:0] r1_q, r1_d;
  logic [W-1:0] r2_q, r2_d;
  logic [15:0]  word_count_q, word_count_d;

  logic rnd_take;
  logic out_take;

  assign rnd_take = (state_q == StFetch) && rnd_valid_i;
  assign out_take = (state_q == StEmit) && out_ready_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a0_d         = a0_q;
    a1_d         = a1_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    r0_d         = r0_q;
    r1_d         = r1_q;
    r2_d         = r2_q;
    word_count_d = word_count_q;

    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          // Plaintext sits in a0/b0 only until its mask arrives in slot 0/1.
          a0_d    = in_a_i;
          b0_d    = in_b_i;
          cnt_d   = 3'd0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (rnd_take) begin
          cnt_d = cnt_q + 3'd1;
          case (cnt_q)
            3'd0: begin
              a0_d = a0_q ^ rnd_data_i;
              a1_d = rnd_data_i;
            end
            3'd1: begin
              b0_d = b0_q ^ rnd_data_i;
              b1_d = rnd_data_i;
            end
            3'd2: r0_d = rnd_data_i;
            3'd3: r1_d = rnd_data_i;
            3'd4: begin
              r2_d    = rnd_data_i;
              state_d = StEmit;
            end
            default: begin
              cnt_d   = 3'd0;
              state_d = StIdle;
            end
          endcase
        end
      end
      StEmit: begin
        if (out_take) begin
          // Zeroize so no share or mask lingers once the bundle is consumed.
          a0_d         = '0;
          a1_d         = '0;
          b0_d         = '0;
          b1_d         = '0;
          r0_d         = '0;
          r1_d         = '0;
          r2_d         = '0;
          word_count_d = word_count_q + 16'd1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      a0_q         <= '0;
      a1_q         <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      r0_q         <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a0_q         <= a0_d;
      a1_q         <= a1_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      r0_q         <= r0_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready_o   = (state_q == StIdle);
  assign rnd_ready_o  = (state_q == StFetch);
  assign out_valid_o  = (state_q == StEmit);
  assign a0_o         = a0_q;
  assign a1_o         = a1_q;
  assign b0_o         = b0_q;
  assign b1_o         = b1_q;
  assign r0_o         = r0_q;
  assign r1_o         = r1_q;
  assign r2_o         = r2_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_xor_share_encoder.sv
// Scoreboard bench for xor_share_encoder: driver pushes expected bundles, monitor pops
// and compares on every EMIT handshake.
module tb_xor_share_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [7:0]  rnd_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  a0, a1, b0, b1, r0, r1, r2;
  logic [15:0] word_count;

  xor_share_encoder #(.W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .rnd_valid_i  (rnd_valid),
    .rnd_ready_o  (rnd_ready),
    .rnd_data_i   (rnd_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .a0_o         (a0),
    .a1_o         (a1),
    .b0_o         (b0),
    .b1_o         (b1),
    .r0_o         (r0),
    .r1_o         (r1),
    .r2_o         (r2),
    .word_count_o (word_count)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [55:0] bundle;  // {a0,a1,b0,b1,r0,r1,r2}
    int          t0;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] exp_wc = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] dut_bundle();
    return {a0, a1, b0, b1, r0, r1, r2};
  endfunction

  // One full bundle. rv holds slot s in rv[8*s +: 8]; hand != 0 overrides the model.
  task automatic encode(input logic [7:0] a, input logic [7:0] b, input logic [39:0] rv,
                        input int stall_slot, input int stall_len, input int hold,
                        input logic [55:0] hand);
    exp_t e;
    logic [7:0] rs [5];
    for (int s = 0; s < 5; s++) rs[s] = rv[8*s +: 8];
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    e.a      = a;
    e.b      = b;
    e.t0     = cyc;
    e.lat    = 6 + stall_len;
    e.bundle = (hand != 56'd0) ? hand
             : {a ^ rs[0], rs[0], b ^ rs[1], rs[1], rs[2], rs[3], rs[4]};
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 8'hEE;
    in_b     = 8'hEE;
    for (int s = 0; s < 5; s++) begin
      if (s == stall_slot) begin
        rnd_valid = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      rnd_valid = 1'b1;
      rnd_data  = rs[s];
      @(negedge clk);
    end
    rnd_valid = 1'b0;
    rnd_data  = 8'hC3;
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < hold; i++) begin
        #2;
        check("hold out_valid", {63'd0, out_valid}, 64'd1);
        check("hold in_ready", {63'd0, in_ready}, 64'd0);
        check("hold bundle", {8'd0, dut_bundle()}, {8'd0, e.bundle});
        @(negedge clk);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_wc    = exp_wc + 16'd1;
    #2;
    check("post in_ready", {63'd0, in_ready}, 64'd1);
    check("post zeroized", {8'd0, dut_bundle()}, 64'd0);
    check("word_count", {48'd0, word_count}, {48'd0, exp_wc});
  endtask

  // Monitor: latency, bundle content, randomness usage and gadget-level recombination.
  initial begin : monitor
    int   rnd_cnt;
    logic in_emit;
    exp_t e;
    rnd_cnt = 0;
    in_emit = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        rnd_cnt = 0;
        in_emit = 1'b0;
      end else begin
        if (rnd_valid && rnd_ready) rnd_cnt++;
        if (out_valid === 1'b1) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious out_valid: got 1, expected 0 at cycle %0d", cyc);
          end else begin
            e = sb[0];
            if (!in_emit) begin
              in_emit = 1'b1;
              check("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
            if (out_ready) begin
              void'(sb.pop_front());
              check("bundle", {8'd0, dut_bundle()}, {8'd0, e.bundle});
              check("rnd consumed", 64'(rnd_cnt), 64'd5);
              check("gadget a^b", {56'd0, a0 ^ a1 ^ b0 ^ b1}, {56'd0, e.a ^ e.b});
              if (a1 != 8'd0) check("a masked", {63'd0, a0 == e.a}, 64'd0);
              rnd_cnt = 0;
              in_emit = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : driver
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    rnd_valid = 1'b0;
    rnd_data  = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset rnd_ready", {63'd0, rnd_ready}, 64'd0);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset shares", {8'd0, dut_bundle()}, 64'd0);
    check("reset word_count", {48'd0, word_count}, 64'd0);

    // Basic encode with hand-computed shares.
    encode(8'h5A, 8'h3C, 40'h5544332211, -1, 0, 0, 56'h4B_11_1E_22_33_44_55);
    // Randomness stall of 3 cycles before slot 3.
    encode(8'h5A, 8'h3C, 40'h5544332211, 3, 3, 0, 56'h4B_11_1E_22_33_44_55);
    // Backpressure for 10 cycles in EMIT.
    encode(8'hC3, 8'h96, 40'h0F_F0_81_7E_A5, -1, 0, 10, 56'h0);

    // Reset after slot 2 aborts the bundle.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 8'h5A;
    in_b     = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      rnd_valid = 1'b1;
      rnd_data  = 8'h11 * (s + 1);
      @(negedge clk);
    end
    rnd_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    exp_wc = 16'd0;
    #2;
    check("abort in_ready", {63'd0, in_ready}, 64'd1);
    check("abort rnd_ready", {63'd0, rnd_ready}, 64'd0);
    check("abort out_valid", {63'd0, out_valid}, 64'd0);
    check("abort shares", {8'd0, dut_bundle()}, 64'd0);
    check("abort word_count", {48'd0, word_count}, 64'd0);
    encode(8'hFF, 8'h00, 40'hA5A5A5A5A5, -1, 0, 0, 56'h5A_A5_A5_A5_A5_A5_A5);

    // Random sweep, some with a stall.
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  ra, rb;
      logic [39:0] rr;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rr = {8'($urandom), $urandom};
      if (i % 4 == 3) encode(ra, rb, rr, int'($urandom_range(0, 4)), 2, 0, 56'h0);
      else encode(ra, rb, rr, -1, 0, 0, 56'h0);
    end

    // Counter wrap 0xFFFF -> 0x0000.
    @(negedge clk);
    force dut.word_count_q = 16'hFFFE;
    #1;
    release dut.word_count_q;
    exp_wc = 16'hFFFE;
    encode(8'h12, 8'h34, 40'h0102030405, -1, 0, 0, 56'h0);
    encode(8'h56, 8'h78, 40'h1020304050, -1, 0, 0, 56'h0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d bundles outstanding, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
